// File: rtl/seq_pkg.sv
// Shared types and the reset-table helper for the pattern sequencer.
package seq_pkg;

  // Entry fields are sized for the widest supported OUT_W (16). Users keep
  // only the low OUT_W bits, which gives the modulo-2^OUT_W reset values.
  localparam int ENTRY_W_MAX = 16;

  typedef struct packed {
    logic [ENTRY_W_MAX-1:0] out1;
    logic [ENTRY_W_MAX-1:0] out2;
  } step_entry_t;

  // Step transition chosen on each clock edge.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_RESTART,
    ACT_JUMP,
    ACT_ADVANCE,
    ACT_WRAP,
    ACT_RECOVER
  } step_act_e;

  // Power-on contents of entry idx: out1 counts up from 1, out2 counts down
  // to 0 at the last step.
  function automatic step_entry_t reset_entry(input int idx, input int num_steps);
    step_entry_t e;
    e.out1 = ENTRY_W_MAX'(idx + 1);
    e.out2 = ENTRY_W_MAX'(num_steps - 1 - idx);
    return e;
  endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Control, table-write and status bundle of the pattern sequencer.
interface pattern_sequencer_if #(
  parameter int NUM_STEPS = 5,
  parameter int OUT_W     = 3,
  parameter int PCNT_W    = 8
);
  localparam int SW = $clog2(NUM_STEPS);

  logic              restart;
  logic              pause;
  logic              jump;
  logic [SW-1:0]     jump_step;
  logic              mode_loop;
  logic              tbl_we;
  logic [SW-1:0]     tbl_addr;
  logic [OUT_W-1:0]  tbl_out1;
  logic [OUT_W-1:0]  tbl_out2;
  logic [SW-1:0]     step;
  logic [OUT_W-1:0]  out1;
  logic [OUT_W-1:0]  out2;
  logic              even;
  logic              odd;
  logic              terminal;
  logic [PCNT_W-1:0] pass_cnt;

  modport master (
    output restart, pause, jump, jump_step, mode_loop,
           tbl_we, tbl_addr, tbl_out1, tbl_out2,
    input  step, out1, out2, even, odd, terminal, pass_cnt
  );

  modport slave (
    input  restart, pause, jump, jump_step, mode_loop,
           tbl_we, tbl_addr, tbl_out1, tbl_out2,
    output step, out1, out2, even, odd, terminal, pass_cnt
  );

endinterface

// File: rtl/seq_table.sv
// Step table: one register pair per step, one write port, one async read port.
module seq_table
  import seq_pkg::*;
#(
  parameter  int NUM_STEPS = 5,
  parameter  int OUT_W     = 3,
  localparam int SW        = $clog2(NUM_STEPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [SW-1:0]    waddr_i,
  input  logic [OUT_W-1:0] wout1_i,
  input  logic [OUT_W-1:0] wout2_i,
  input  logic [SW-1:0]    raddr_i,
  output logic [OUT_W-1:0] rout1_o,
  output logic [OUT_W-1:0] rout2_o
);

  logic [OUT_W-1:0] out1_all [NUM_STEPS];
  logic [OUT_W-1:0] out2_all [NUM_STEPS];

  // Addresses at or above NUM_STEPS match no entry, so those writes vanish.
  for (genvar gi = 0; gi < NUM_STEPS; gi++) begin : g_entry
    localparam step_entry_t RST_E = reset_entry(gi, NUM_STEPS);
    logic [OUT_W-1:0] out1_q;
    logic [OUT_W-1:0] out2_q;

    // Entry register; reset restores the power-on pattern and beats any write.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        out1_q <= RST_E.out1[OUT_W-1:0];
        out2_q <= RST_E.out2[OUT_W-1:0];
      end else if (we_i && (waddr_i == SW'(gi))) begin
        out1_q <= wout1_i;
        out2_q <= wout2_i;
      end
    end

    assign out1_all[gi] = out1_q;
    assign out2_all[gi] = out2_q;
  end

  // Read mux; an out-of-range address reads zero.
  always_comb begin
    rout1_o = '0;
    rout2_o = '0;
    for (int i = 0; i < NUM_STEPS; i++) begin
      if (raddr_i == SW'(i)) begin
        rout1_o = out1_all[i];
        rout2_o = out2_all[i];
      end
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Step sequencer: walks a programmable table, with restart/jump/pause control
// and a saturating count of completed loops.
//
//   action       | meaning
//   -------------+-----------------------------------------------------
//   ACT_RECOVER  | step register out of range, reload step 0
//   ACT_RESTART  | restart asserted, step 0, pass count untouched
//   ACT_JUMP     | jump to an in-range jump_step, pass count untouched
//   ACT_HOLD     | pause, or one-shot mode sitting at the last step
//   ACT_ADVANCE  | step + 1
//   ACT_WRAP     | loop mode at last step: step 0, pass count + 1 (sat)
module pattern_sequencer
  import seq_pkg::*;
#(
  parameter  int NUM_STEPS = 5,
  parameter  int OUT_W     = 3,
  parameter  int PCNT_W    = 8,
  localparam int SW        = $clog2(NUM_STEPS)
) (
  input  logic          clk,
  input  logic          reset,
  pattern_sequencer_if.slave bus
);

  localparam logic [SW-1:0] LAST_STEP   = SW'(NUM_STEPS - 1);
  localparam logic [SW:0]   NUM_STEPS_W = (SW+1)'(NUM_STEPS);

  logic [SW-1:0]     step_q;
  logic [SW-1:0]     step_d;
  logic [PCNT_W-1:0] pcnt_q;
  logic [PCNT_W-1:0] pcnt_d;
  step_act_e         act;
  logic              step_valid;
  logic              jump_valid;
  logic [OUT_W-1:0]  tbl_out1;
  logic [OUT_W-1:0]  tbl_out2;

  assign step_valid = ({1'b0, step_q} < NUM_STEPS_W);
  assign jump_valid = ({1'b0, bus.jump_step} < NUM_STEPS_W);

  seq_table #(
    .NUM_STEPS (NUM_STEPS),
    .OUT_W     (OUT_W)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .we_i    (bus.tbl_we),
    .waddr_i (bus.tbl_addr),
    .wout1_i (bus.tbl_out1),
    .wout2_i (bus.tbl_out2),
    .raddr_i (step_q),
    .rout1_o (tbl_out1),
    .rout2_o (tbl_out2)
  );

  // State register: current step and pass counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q <= '0;
      pcnt_q <= '0;
    end else begin
      step_q <= step_d;
      pcnt_q <= pcnt_d;
    end
  end

  // Next-state: pick one action by priority, then derive step and count.
  always_comb begin
    act    = ACT_HOLD;
    step_d = step_q;
    if (!step_valid) begin
      act    = ACT_RECOVER;
      step_d = '0;
    end else if (bus.restart) begin
      act    = ACT_RESTART;
      step_d = '0;
    end else if (bus.jump && jump_valid) begin
      act    = ACT_JUMP;
      step_d = bus.jump_step;
    end else if (bus.pause) begin
      act    = ACT_HOLD;
    end else if (step_q != LAST_STEP) begin
      act    = ACT_ADVANCE;
      step_d = step_q + SW'(1);
    end else if (bus.mode_loop) begin
      act    = ACT_WRAP;
      step_d = '0;
    end

    pcnt_d = pcnt_q;
    if ((act == ACT_WRAP) && (pcnt_q != '1)) begin
      pcnt_d = pcnt_q + PCNT_W'(1);
    end
  end

  // Outputs: all derived from the current step with no added latency.
  always_comb begin
    bus.step     = step_q;
    bus.odd      = ~step_q[0];
    bus.even     = step_q[0];
    bus.terminal = (step_q == LAST_STEP);
    bus.pass_cnt = pcnt_q;
    bus.out1     = tbl_out1;
    bus.out2     = tbl_out2;
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: directed vectors, saturation, async reset, and
// random traffic against a behavioural model.
module tb_pattern_sequencer;

  localparam int N  = 5;
  localparam int OW = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  pattern_sequencer_if #(.NUM_STEPS(N), .OUT_W(OW), .PCNT_W(8)) ifa ();
  pattern_sequencer_if #(.NUM_STEPS(N), .OUT_W(OW), .PCNT_W(2)) ifb ();

  pattern_sequencer #(.NUM_STEPS(N), .OUT_W(OW), .PCNT_W(8)) u_dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  pattern_sequencer #(.NUM_STEPS(N), .OUT_W(OW), .PCNT_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rs, pa, jp; int js; bit ml, we; int wa, w1, w2;
    int e_step, e_o1, e_o2, e_term, e_pcnt;
  } vec_t;

  vec_t vecs[$];

  // behavioural model
  int m_step, m_pcnt;
  int m_t1[N];
  int m_t2[N];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_a(input string nm, input int es, input int e1, input int e2,
                         input int et, input int ep);
    chk({nm, ".step"},     ifa.step,     es);
    chk({nm, ".out1"},     ifa.out1,     e1);
    chk({nm, ".out2"},     ifa.out2,     e2);
    chk({nm, ".terminal"}, ifa.terminal, et);
    chk({nm, ".odd"},      ifa.odd,      (es % 2 == 0) ? 1 : 0);
    chk({nm, ".even"},     ifa.even,     (es % 2 == 0) ? 0 : 1);
    chk({nm, ".pass_cnt"}, ifa.pass_cnt, ep);
  endtask

  task automatic drive_a(input bit rs, pa, jp, input int js, input bit ml, we,
                         input int wa, w1, w2);
    ifa.restart   = rs;
    ifa.pause     = pa;
    ifa.jump      = jp;
    ifa.jump_step = 3'(js);
    ifa.mode_loop = ml;
    ifa.tbl_we    = we;
    ifa.tbl_addr  = 3'(wa);
    ifa.tbl_out1  = 3'(w1);
    ifa.tbl_out2  = 3'(w2);
  endtask

  function automatic vec_t mk(bit rs, bit pa, bit jp, int js, bit ml, bit we, int wa,
                              int w1, int w2, int es, int e1, int e2, int et, int ep);
    vec_t v;
    v.rs = rs; v.pa = pa; v.jp = jp; v.js = js; v.ml = ml; v.we = we;
    v.wa = wa; v.w1 = w1; v.w2 = w2;
    v.e_step = es; v.e_o1 = e1; v.e_o2 = e2; v.e_term = et; v.e_pcnt = ep;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_t1[i] = (i + 1) % (1 << OW);
      m_t2[i] = (N - 1 - i) % (1 << OW);
    end
    m_step = 0;
    m_pcnt = 0;
  endtask

  task automatic model_step(input bit rs, pa, jp, input int js, input bit ml, we,
                            input int wa, w1, w2);
    if (we && wa < N) begin
      m_t1[wa] = w1;
      m_t2[wa] = w2;
    end
    if (rs)                m_step = 0;
    else if (jp && js < N) m_step = js;
    else if (pa)           m_step = m_step;
    else if (m_step < N-1) m_step = m_step + 1;
    else if (ml) begin
      m_step = 0;
      if (m_pcnt < 255) m_pcnt = m_pcnt + 1;
    end
  endtask

  initial begin
    // vectors: rs pa jp js ml we wa w1 w2 | step out1 out2 term pcnt
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,0,0,0,1,0,0,0,0, i+1, i+2, 3-i, (i==3), 0));
    vecs.push_back(mk(0,0,0,0,1,0,0,0,0, 0,1,4,0,1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,0,0,0,0,0,0,0,0, i+1, i+2, 3-i, (i==3), 1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 4,5,0,1,1));
    vecs.push_back(mk(1,0,1,2,0,0,0,0,0, 0,1,4,0,1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,0,0,0,0,0,0,0,0, i+1, i+2, 3-i, (i==3), 1));
    vecs.push_back(mk(0,0,1,2,0,0,0,0,0, 2,3,2,0,1));
    vecs.push_back(mk(0,1,1,7,0,0,0,0,0, 2,3,2,0,1));
    vecs.push_back(mk(0,0,0,0,1,0,0,0,0, 3,4,1,0,1));
    vecs.push_back(mk(0,0,0,0,1,0,0,0,0, 4,5,0,1,1));
    vecs.push_back(mk(0,0,1,0,1,0,0,0,0, 0,1,4,0,1));
    vecs.push_back(mk(0,0,1,6,1,0,0,0,0, 1,2,3,0,1));
    vecs.push_back(mk(0,1,1,5,1,0,0,0,0, 1,2,3,0,1));
    vecs.push_back(mk(0,0,0,0,1,0,0,0,0, 2,3,2,0,1));
    vecs.push_back(mk(0,0,0,0,1,0,0,0,0, 3,4,1,0,1));
    vecs.push_back(mk(0,1,0,0,1,1,3,6,1, 3,6,1,0,1));
    vecs.push_back(mk(0,1,0,0,1,1,5,7,7, 3,6,1,0,1));
    vecs.push_back(mk(0,0,0,0,1,1,4,2,5, 4,2,5,1,1));
    vecs.push_back(mk(1,0,0,0,1,0,0,0,0, 0,1,4,0,1));
    vecs.push_back(mk(0,0,0,0,1,0,0,0,0, 1,2,3,0,1));
    vecs.push_back(mk(0,0,0,0,1,0,0,0,0, 2,3,2,0,1));
    vecs.push_back(mk(0,0,0,0,1,0,0,0,0, 3,6,1,0,1));
    vecs.push_back(mk(0,1,0,0,1,0,0,0,0, 3,6,1,0,1));
    vecs.push_back(mk(0,0,0,0,1,0,0,0,0, 4,2,5,1,1));
    vecs.push_back(mk(0,1,0,0,1,0,0,0,0, 4,2,5,1,1));
    vecs.push_back(mk(0,0,0,0,1,0,0,0,0, 0,1,4,0,2));
    vecs.push_back(mk(0,0,0,0,1,1,7,0,0, 1,2,3,0,2));
    vecs.push_back(mk(0,1,0,0,1,1,1,5,5, 1,5,5,0,2));

    // reset state
    drive_a(0,0,0,0,1,0,0,0,0);
    ifb.restart = 0; ifb.pause = 0; ifb.jump = 0; ifb.jump_step = '0;
    ifb.mode_loop = 0; ifb.tbl_we = 0; ifb.tbl_addr = '0;
    ifb.tbl_out1 = '0; ifb.tbl_out2 = '0;
    reset = 1'b1;
    #12;
    check_a("reset", 0, 1, 4, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // directed vector table
    foreach (vecs[k]) begin
      drive_a(vecs[k].rs, vecs[k].pa, vecs[k].jp, vecs[k].js, vecs[k].ml,
              vecs[k].we, vecs[k].wa, vecs[k].w1, vecs[k].w2);
      @(posedge clk); #1;
      check_a($sformatf("vec%0d", k), vecs[k].e_step, vecs[k].e_o1, vecs[k].e_o2,
              vecs[k].e_term, vecs[k].e_pcnt);
    end

    // pass counter saturation on the 2-bit instance
    drive_a(0,0,0,0,1,0,0,0,0);
    ifb.mode_loop = 1;
    reset = 1'b1; #3; reset = 1'b0;
    for (int p = 1; p <= 5; p++) begin
      repeat (5) @(posedge clk);
      #1;
      chk($sformatf("sat%0d.step", p), ifb.step, 0);
      chk($sformatf("sat%0d.pass_cnt", p), ifb.pass_cnt, (p < 3) ? p : 3);
    end

    // asynchronous reset mid-cycle restores step, count and table
    reset = 1'b1; #3; reset = 1'b0;
    drive_a(0,0,0,0,1,1,0,7,6);
    @(posedge clk); #1;
    drive_a(0,0,0,0,1,0,0,0,0);
    repeat (9) @(posedge clk);
    #1;
    check_a("pre_rst_wrap", 0, 7, 6, 0, 2);
    repeat (3) @(posedge clk);
    #1;
    check_a("pre_rst_s3", 3, 4, 1, 0, 2);
    #3;
    reset = 1'b1;
    drive_a(0,0,0,0,1,1,0,5,5);
    #1;
    check_a("async_rst", 0, 1, 4, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_a("rst_vs_write", 0, 1, 4, 0, 0);
    drive_a(0,0,0,0,1,0,0,0,0);
    reset = 1'b0;

    // random traffic against the model
    #2;
    reset = 1'b1; #2; reset = 1'b0;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      bit rs, pa, jp, ml, we;
      int js, wa, w1, w2;
      rs = ($urandom_range(15) == 0);
      jp = ($urandom_range(7) == 0);
      pa = ($urandom_range(3) == 0);
      ml = ($urandom_range(7) != 0);
      we = ($urandom_range(3) == 0);
      js = $urandom_range(7);
      wa = $urandom_range(7);
      w1 = $urandom_range(7);
      w2 = $urandom_range(7);
      drive_a(rs, pa, jp, js, ml, we, wa, w1, w2);
      @(posedge clk); #1;
      model_step(rs, pa, jp, js, ml, we, wa, w1, w2);
      check_a($sformatf("rnd%0d", c), m_step, m_t1[m_step], m_t2[m_step],
              (m_step == N-1) ? 1 : 0, m_pcnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 SHALL have parameter NUM_STEPS, default 5, number of sequence steps (legal 2..16).
REQ-002 SHALL have parameter OUT_W, default 3, width of out1/out2 and table data.
REQ-003 SHALL have parameter PCNT_W, default 8, width of pass_cnt.
REQ-004 SHALL have local parameter SW = clog2(NUM_STEPS), step index width.
REQ-005 SHALL have ports: clk  in  1  clock; reset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: restart  in  1  return to step 0; pause  in  1  hold current step.
REQ-007 SHALL have ports: jump  in  1  load jump_step; jump_step  in  SW  jump target index.
REQ-008 SHALL have ports: mode_loop  in  1  1 = wrap after last step, 0 = one-shot hold.
REQ-009 SHALL have ports: tbl_we  in  1  table write strobe; tbl_addr  in  SW  entry to write.
REQ-010 SHALL have ports: tbl_out1  in  OUT_W  out1 write data; tbl_out2  in  OUT_W  out2 write data.
REQ-011 SHALL have ports: step  out  SW  current index; out1, out2  out  OUT_W  table outputs for the current step.
REQ-012 SHALL have ports: even, odd  out  1  parity of 1-based step number; terminal  out  1  at last step.
REQ-013 SHALL have port: pass_cnt  out  PCNT_W  completed wraps, saturating.

Function
REQ-014 SHALL hold state in a step register of SW bits and a table of NUM_STEPS entries {out1, out2}.
REQ-015 SHALL drive out1/out2 combinationally from table[step], with no pipeline latency.
REQ-016 SHALL drive odd = 1 when step is even (1-based step number odd), and even = ~odd.
REQ-017 SHALL drive terminal = 1 iff step == NUM_STEPS-1.
REQ-018 SHALL resolve each clk edge with priority restart > jump > pause > advance.
REQ-019 restart: step <- 0; pass_cnt unchanged.
REQ-020 jump with jump_step < NUM_STEPS: step <- jump_step; jump_step >= NUM_STEPS: jump is ignored and evaluation falls through to pause/advance.
REQ-021 pause: step is held.
REQ-022 advance, step < NUM_STEPS-1: step <- step+1.
REQ-023 advance at last step, mode_loop = 1: step <- 0 and pass_cnt increments, saturating at all-ones.
REQ-024 advance at last step, mode_loop = 0: step is held and pass_cnt is unchanged.
REQ-025 SHALL never increment pass_cnt on restart or jump, including a jump to step 0.
REQ-026 SHALL write table[tbl_addr] on a clk edge when tbl_we = 1 and tbl_addr < NUM_STEPS; out-of-range writes are ignored.
REQ-027 A write to the current step SHALL appear on out1/out2 in the cycle after the write edge.
REQ-028 A table write SHALL be independent of, and concurrent with, any step transition in the same cycle.
REQ-029 If the step register holds an index >= NUM_STEPS, the next edge SHALL load step 0.

Reset
REQ-030 reset SHALL asynchronously force step = 0 and pass_cnt = 0.
REQ-031 reset SHALL asynchronously load table[i] = {out1 = (i+1) mod 2^OUT_W, out2 = (NUM_STEPS-1-i) mod 2^OUT_W}.
REQ-032 Output values during reset SHALL be: step 0, odd 1, even 0, terminal 0, out1 = 1, out2 = NUM_STEPS-1 truncated.
REQ-033 reset SHALL override all inputs, including a table write in progress.

Structure
REQ-034 A shared package seq_pkg SHALL hold the step_entry_t struct {out1, out2} and the reset-table function.
REQ-035 The table SHALL be a single sub-module, seq_table (register array, one write port, one asynchronous read port); the FSM and pass counter live in pattern_sequencer.

Verification
REQ-036 Defaults, reset, inputs idle, mode_loop = 1 for 5 clks -> step 0,1,2,3,4 then 0; out1 1,2,3,4,5; terminal high only at step 4; pass_cnt = 1.
REQ-037 mode_loop = 0, run to step 4, 3 more clks -> step stays 4, terminal = 1, pass_cnt = 0.
REQ-038 At step 4, assert jump = 1, jump_step = 2, and restart = 1 together -> step 0; repeat with restart = 0 -> step 2, odd = 1; jump_step = 7 with pause = 1 -> step held.
REQ-039 At step 3, tbl_we = 1, tbl_addr = 3, tbl_out1 = 6, tbl_out2 = 1, pause = 1 -> next cycle out1 = 6, out2 = 1, step 3.
REQ-040 PCNT_W = 2, mode_loop = 1, 5 full passes -> pass_cnt 1,2,3,3,3.
REQ-041 Assert reset asynchronously mid-cycle at step 3 with pass_cnt = 2 -> immediately step 0, pass_cnt 0, table restored to its reset values.
